// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, decode enums, the decode->execute
// bundle and small decode helpers.
package core_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pcplus;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic [1:0]  alu_src;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic        reg_write;
    wb_sel_e     wb_sel;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ex_bundle_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e t);
    case (t)
      IMM_I:   gen_imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   gen_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   gen_imm = {instr[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: gen_imm = '0;
    endcase
  endfunction

  // alt selects SUB over ADD and SRA over SRL (instr bit 30)
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 integer register file: two read ports with write-through bypass,
// one write port, x0 hardwired to zero.
module reg_file (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != 5'd0) rs1_data = (we && wr_addr == rs1) ? wr_data : regs[rs1];
    if (rs2 != 5'd0) rs2_data = (we && wr_addr == rs2) ? wr_data : regs[rs2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetch output, reads operands, detects load-use
// hazards and registers one bundle per cycle. DECODE_ILLEGAL_TRAP_EN flags illegal words.
module decode_stage
  import core_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] fetch_instr_i,
  input  logic [31:0] fetch_pc_i,
  input  logic [31:0] fetch_pcplus_i,
  output logic        fetch_ready_o,
  input  logic        br_taken_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        ex_ready_i,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_pcplus_o,
  output logic [31:0] ex_rs1_data_o,
  output logic [31:0] ex_rs2_data_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rs1_o,
  output logic [4:0]  ex_rs2_o,
  output logic [4:0]  ex_rd_o,
  output logic [3:0]  ex_alu_op_o,
  output logic [1:0]  ex_alu_src_o,
  output logic        ex_mem_read_o,
  output logic        ex_mem_write_o,
  output logic [2:0]  ex_mem_size_o,
  output logic        ex_reg_write_o,
  output logic [1:0]  ex_wb_sel_o,
  output logic        ex_branch_o,
  output logic        ex_jump_o,
  output logic        ex_illegal_o
);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [6:0]  raw_opc;
  logic [2:0]  raw_f3;
  logic [6:0]  raw_f7;
  logic        illegal_raw;
  logic [31:0] instr;
  logic [2:0]  f3;

  imm_type_e   imm_type;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic [1:0]  alu_src;
  logic        use_rs1, use_rs2, use_rd;
  logic        mem_read, mem_write, branch, jump;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] rs1_data, rs2_data;
  logic        hazard;

  ex_bundle_t  d, q;

  assign raw_opc = fetch_instr_i[6:0];
  assign raw_f3  = fetch_instr_i[14:12];
  assign raw_f7  = fetch_instr_i[31:25];

  // Opcodes with non-11 low bits never match a case item, so they land in default.
  always_comb begin
    illegal_raw = 1'b0;
    case (raw_opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM: illegal_raw = 1'b0;
      OPC_JALR:   illegal_raw = (raw_f3 != 3'b000);
      OPC_BRANCH: illegal_raw = (raw_f3 == 3'b010) || (raw_f3 == 3'b011);
      OPC_LOAD:   illegal_raw = (raw_f3 == 3'b011) || (raw_f3 == 3'b110) || (raw_f3 == 3'b111);
      OPC_STORE:  illegal_raw = (raw_f3 > 3'b010);
      OPC_OP_IMM: illegal_raw = (raw_f3 == 3'b001 && raw_f7 != 7'b0000000) ||
                                (raw_f3 == 3'b101 && raw_f7 != 7'b0000000 && raw_f7 != 7'b0100000);
      OPC_OP:     illegal_raw = !(raw_f7 == 7'b0000000 ||
                                  (raw_f7 == 7'b0100000 && (raw_f3 == 3'b000 || raw_f3 == 3'b101)));
      default:    illegal_raw = 1'b1;
    endcase
  end

  // Everything that must behave as a NOP is decoded as the canonical NOP word.
  assign instr = (illegal_raw || raw_opc == OPC_MISC_MEM || raw_opc == OPC_SYSTEM) ? NOP_INSTR
                                                                                   : fetch_instr_i;
  assign f3 = instr[14:12];

  always_comb begin
    imm_type  = IMM_NONE;
    alu_op    = ALU_ADD;
    alu_src   = 2'b00;
    wb_sel    = WB_ALU;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    case (instr[6:0])
      OPC_LUI: begin
        imm_type = IMM_U; alu_op = ALU_PASSB; alu_src = 2'b10; use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U; alu_src = 2'b11; use_rd = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J; alu_src = 2'b11; use_rd = 1'b1; jump = 1'b1; wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        imm_type = IMM_I; alu_src = 2'b10; use_rs1 = 1'b1; use_rd = 1'b1;
        jump = 1'b1; wb_sel = WB_PC4;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; branch = 1'b1;
        case (f3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          default: alu_op = ALU_SLTU;
        endcase
      end
      OPC_LOAD: begin
        imm_type = IMM_I; alu_src = 2'b10; use_rs1 = 1'b1; use_rd = 1'b1;
        mem_read = 1'b1; wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        imm_type = IMM_S; alu_src = 2'b10; use_rs1 = 1'b1; use_rs2 = 1'b1; mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I; alu_src = 2'b10; use_rs1 = 1'b1; use_rd = 1'b1;
        alu_op = alu_from_f3(f3, f3 == 3'b101 && instr[30]);
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        alu_op = alu_from_f3(f3, instr[30]);
      end
      default: ;
    endcase
  end

  // Unused index fields are zeroed so they cannot match a hazard or forwarding compare.
  assign rs1_idx = use_rs1 ? instr[19:15] : 5'd0;
  assign rs2_idx = use_rs2 ? instr[24:20] : 5'd0;
  assign rd_idx  = use_rd  ? instr[11:7]  : 5'd0;

  reg_file u_reg_file (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .rs1      (rs1_idx),
    .rs2      (rs2_idx),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_we_i),
    .wr_addr  (wb_rd_i),
    .wr_data  (wb_data_i)
  );

  assign hazard = q.valid && q.mem_read && (q.rd != 5'd0) &&
                  ((rs1_idx == q.rd) || (rs2_idx == q.rd));
  assign fetch_ready_o = ex_ready_i && !hazard;

  always_comb begin
    d           = '0;
    d.valid     = 1'b1;
    d.pc        = fetch_pc_i;
    d.pcplus    = fetch_pcplus_i;
    d.rs1_data  = rs1_data;
    d.rs2_data  = rs2_data;
    d.imm       = gen_imm(instr, imm_type);
    d.rs1       = rs1_idx;
    d.rs2       = rs2_idx;
    d.rd        = rd_idx;
    d.alu_op    = alu_op;
    d.alu_src   = alu_src;
    d.mem_read  = mem_read;
    d.mem_write = mem_write;
    d.mem_size  = (mem_read || mem_write) ? f3 : 3'b000;
    d.reg_write = use_rd && (rd_idx != 5'd0);
    d.wb_sel    = wb_sel;
    d.branch    = branch;
    d.jump      = jump;
    d.illegal   = TRAP_EN && illegal_raw;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q    <= '0;
      q.pc <= BOOT_ADDR;
    end else if (br_taken_i) begin
      q <= '0;
    end else if (ex_ready_i) begin
      q <= hazard ? '0 : d;
    end
  end

  assign ex_valid_o     = q.valid;
  assign ex_pc_o        = q.pc;
  assign ex_pcplus_o    = q.pcplus;
  assign ex_rs1_data_o  = q.rs1_data;
  assign ex_rs2_data_o  = q.rs2_data;
  assign ex_imm_o       = q.imm;
  assign ex_rs1_o       = q.rs1;
  assign ex_rs2_o       = q.rs2;
  assign ex_rd_o        = q.rd;
  assign ex_alu_op_o    = q.alu_op;
  assign ex_alu_src_o   = q.alu_src;
  assign ex_mem_read_o  = q.mem_read;
  assign ex_mem_write_o = q.mem_write;
  assign ex_mem_size_o  = q.mem_size;
  assign ex_reg_write_o = q.reg_write;
  assign ex_wb_sel_o    = q.wb_sel;
  assign ex_branch_o    = q.branch;
  assign ex_jump_o      = q.jump;
  assign ex_illegal_o   = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes the expected ex_* bundle,
// a monitor pops and compares one entry after every rising edge.
module tb_decode_stage;

  localparam logic [31:0] BOOT = 32'h0000_1000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [3:0]  A_ADD = 4'd0, A_SUB = 4'd1, A_SRA = 4'd7, A_PASSB = 4'd10;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, pcplus, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic        mr, mw;
    logic [2:0]  msize;
    logic        rw;
    logic [1:0]  wb;
    logic        br, j, ill;
  } exp_t;

  typedef struct {
    string nm;
    exp_t  e;
  } sb_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] fetch_instr_i, fetch_pc_i, fetch_pcplus_i;
  logic        fetch_ready_o, br_taken_i, wb_we_i, ex_ready_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        ex_valid_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o;
  logic        ex_branch_o, ex_jump_o, ex_illegal_o;
  logic [31:0] ex_pc_o, ex_pcplus_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [3:0]  ex_alu_op_o;
  logic [1:0]  ex_alu_src_o, ex_wb_sel_o;
  logic [2:0]  ex_mem_size_o;

  exp_t act;
  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  decode_stage #(.BOOT_ADDR(BOOT)) dut (
    .clk_i, .rst_ni, .fetch_instr_i, .fetch_pc_i, .fetch_pcplus_i, .fetch_ready_o,
    .br_taken_i, .wb_we_i, .wb_rd_i, .wb_data_i, .ex_ready_i, .ex_valid_o,
    .ex_pc_o, .ex_pcplus_o, .ex_rs1_data_o, .ex_rs2_data_o, .ex_imm_o,
    .ex_rs1_o, .ex_rs2_o, .ex_rd_o, .ex_alu_op_o, .ex_alu_src_o,
    .ex_mem_read_o, .ex_mem_write_o, .ex_mem_size_o, .ex_reg_write_o,
    .ex_wb_sel_o, .ex_branch_o, .ex_jump_o, .ex_illegal_o
  );

  assign act = {ex_valid_o, ex_pc_o, ex_pcplus_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
                ex_rs1_o, ex_rs2_o, ex_rd_o, ex_alu_op_o, ex_alu_src_o, ex_mem_read_o,
                ex_mem_write_o, ex_mem_size_o, ex_reg_write_o, ex_wb_sel_o,
                ex_branch_o, ex_jump_o, ex_illegal_o};

  function automatic exp_t mk(input logic [31:0] pc, rs1d, rs2d, imm,
                              input logic [4:0] rs1, rs2, rd, input logic [3:0] alu,
                              input logic [1:0] src, input logic mr, mw,
                              input logic [2:0] msize, input logic rw,
                              input logic [1:0] wb, input logic br, j, ill);
    exp_t e;
    e = '{valid: 1'b1, pc: pc, pcplus: pc + 32'd4, rs1d: rs1d, rs2d: rs2d, imm: imm,
          rs1: rs1, rs2: rs2, rd: rd, alu: alu, src: src, mr: mr, mw: mw, msize: msize,
          rw: rw, wb: wb, br: br, j: j, ill: ill};
    return e;
  endfunction

  task automatic step(input string nm, input logic [31:0] instr, pc, input exp_t e,
                      input logic rdy, br, we, input logic [4:0] wrd, input logic [31:0] wdat,
                      input logic chk_rdy, exp_rdy);
    sb_t r;
    @(negedge clk_i);
    fetch_instr_i  = instr;
    fetch_pc_i     = pc;
    fetch_pcplus_i = pc + 32'd4;
    ex_ready_i     = rdy;
    br_taken_i     = br;
    wb_we_i        = we;
    wb_rd_i        = wrd;
    wb_data_i      = wdat;
    r.nm = nm;
    r.e  = e;
    sb_q.push_back(r);
    #1;
    if (chk_rdy) begin
      n_tests++;
      if (fetch_ready_o !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s fetch_ready: got %b expected %b", nm, fetch_ready_o, exp_rdy);
      end
    end
    @(posedge clk_i);
  endtask

  initial begin : monitor
    sb_t r;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        r = sb_q.pop_front();
        n_tests++;
        if (act !== r.e) begin
          n_fail++;
          $display("FAIL %s bundle: got %h expected %h", r.nm, act, r.e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    exp_t rst_e, beq_e, srai_e, bub;
    bub   = '0;
    rst_e = '0;
    rst_e.pc = BOOT;

    rst_ni = 1'b0;
    fetch_instr_i = NOP; fetch_pc_i = '0; fetch_pcplus_i = 32'd4;
    br_taken_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; ex_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (act !== rst_e) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", act, rst_e);
    end
    n_tests++;
    if (fetch_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fetch_ready: got %b expected 1", fetch_ready_o);
    end
    rst_ni = 1'b1;

    step("addi", 32'h0050_0093, 32'h0, mk(32'h0, 0, 0, 32'd5, 0, 0, 1, A_ADD, 2'b10, 0, 0, 0, 1, 0, 0, 0, 0),
         1, 0, 0, 0, 0, 1, 1);
    step("nop_wb", NOP, 32'h4, mk(32'h4, 0, 0, 0, 0, 0, 0, A_ADD, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0),
         1, 0, 1, 5'd6, 32'h66, 1, 1);
    step("lw", 32'h0000_A103, 32'h8, mk(32'h8, 0, 0, 0, 1, 0, 2, A_ADD, 2'b10, 1, 0, 3'b010, 1, 2'd1, 0, 0, 0),
         1, 0, 0, 0, 0, 1, 1);
    step("loaduse_bubble", 32'h0021_01B3, 32'hC, bub, 1, 0, 1, 5'd2, 32'h2222, 1, 0);
    step("loaduse_add", 32'h0021_01B3, 32'hC,
         mk(32'hC, 32'h2222, 32'h2222, 0, 2, 2, 3, A_ADD, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0),
         1, 0, 0, 0, 0, 1, 1);
    step("bypass", 32'h0002_02B3, 32'h10,
         mk(32'h10, 32'hDEADBEEF, 0, 0, 4, 0, 5, A_ADD, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0),
         1, 0, 1, 5'd4, 32'hDEADBEEF, 1, 1);
    beq_e = mk(32'h14, 0, 32'h66, 32'd16, 1, 6, 0, A_SUB, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
    step("beq", 32'h0060_8863, 32'h14, beq_e, 1, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      step("stall_hold", 32'h0010_0393, 32'h18, beq_e, 0, 0, 0, 0, 0, 1, 0);
    step("flush", 32'h0010_0393, 32'h18, bub, 0, 1, 0, 0, 0, 0, 0);
    step("jal", 32'hFF9F_F0EF, 32'h100,
         mk(32'h100, 0, 0, 32'hFFFF_FFF8, 0, 0, 1, A_ADD, 2'b11, 0, 0, 0, 1, 2'd2, 0, 1, 0),
         1, 0, 0, 0, 0, 1, 1);
    step("lui", 32'h1234_5437, 32'h104,
         mk(32'h104, 0, 0, 32'h1234_5000, 0, 0, 8, A_PASSB, 2'b10, 0, 0, 0, 1, 0, 0, 0, 0),
         1, 0, 0, 0, 0, 1, 1);
    step("sw", 32'h0061_2423, 32'h108,
         mk(32'h108, 32'h2222, 32'h66, 32'd8, 2, 6, 0, A_ADD, 2'b10, 0, 1, 3'b010, 0, 0, 0, 0, 0),
         1, 0, 0, 0, 0, 1, 1);
    step("illegal", 32'hFFFF_FFFF, 32'h10C,
         mk(32'h10C, 0, 0, 0, 0, 0, 0, A_ADD, 2'b10, 0, 0, 0, 0, 0, 0, 0, EXP_ILL),
         1, 0, 0, 0, 0, 1, 1);
    srai_e = mk(32'h110, 0, 0, 32'h403, 1, 0, 9, A_SRA, 2'b10, 0, 0, 0, 1, 0, 0, 0, 0);
    step("srai", 32'h4030_D493, 32'h110, srai_e, 1, 0, 0, 0, 0, 1, 1);
    step("hold_pre_rst", 32'h0021_01B3, 32'h114, srai_e, 0, 0, 0, 0, 0, 1, 0);

    @(negedge clk_i);
    ex_ready_i = 1'b0;
    rst_ni     = 1'b0;
    #1;
    n_tests++;
    if (act !== rst_e) begin
      n_fail++;
      $display("FAIL reset_mid_stall: got %h expected %h", act, rst_e);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;

    step("post_reset_regs", 32'h0021_01B3, 32'h200,
         mk(32'h200, 0, 0, 0, 2, 2, 3, A_ADD, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0),
         1, 0, 0, 0, 0, 1, 1);
    step("x0_no_bypass", 32'h0000_05B3, 32'h204,
         mk(32'h204, 0, 0, 0, 0, 0, 11, A_ADD, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0),
         1, 0, 1, 5'd0, 32'h77, 1, 1);
    step("x0_read", 32'h0000_05B3, 32'h208,
         mk(32'h208, 0, 0, 0, 0, 0, 11, A_ADD, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0),
         1, 0, 0, 0, 0, 1, 1);

    repeat (2) @(negedge clk_i);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
